present_enc_ctrl: RTL and testbench

- Sequencing front-end for the PRESENT-80 encryption core; sits directly upstream of it.
- Accepts an 80-bit master key and 64-bit plaintext blocks over valid/ready handshakes.
- Drives the core's data_i/key_load/data_load, counts the 31 rounds, captures the ciphertext from the core's data_o, and presents it on a valid/ready output.
- The core overwrites its key register during rounds, so this block keeps a master-key copy and reloads it before every block.

---
 rtl/present_enc_ctrl_if.sv | 26 ++
 rtl/present_enc_ctrl.sv | 156 +++++++++++++++
 tb/tb_present_enc_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/present_enc_ctrl_if.sv
// Key / plaintext / ciphertext valid-ready bundle for present_enc_ctrl.
// The slave modport is the controller's view; master is the upstream/downstream side.
interface present_enc_ctrl_if #(
    parameter int unsigned KEY_W = 80,
    parameter int unsigned BLK_W = 64
);
    logic [KEY_W-1:0] key;
    logic             key_valid;
    logic             key_ready;
    logic [BLK_W-1:0] pt;
    logic             pt_valid;
    logic             pt_ready;
    logic [BLK_W-1:0] ct;
    logic             ct_valid;
    logic             ct_ready;

    modport master (
        output key, key_valid, pt, pt_valid, ct_ready,
        input  key_ready, pt_ready, ct, ct_valid
    );

    modport slave (
        input  key, key_valid, pt, pt_valid, ct_ready,
        output key_ready, pt_ready, ct, ct_valid
    );
endinterface

// File: rtl/present_enc_ctrl.sv
// Sequencing front-end for a PRESENT-80 core: reloads the master key, loads the block,
// counts rounds and hands out the ciphertext. Optional prefetch: PRESENT_ENC_CTRL_PT_PREFETCH_EN.
module present_enc_ctrl #(
    parameter int unsigned NUM_ROUNDS = 31,
    parameter int unsigned KEY_W      = 80,
    parameter int unsigned BLK_W      = 64
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    present_enc_ctrl_if.slave    bus,
    output logic                 busy_o,
    output logic [KEY_W-1:0]     core_data_i_o,
    output logic                 core_key_load_o,
    output logic                 core_data_load_o,
    input  logic [BLK_W-1:0]     core_data_o_i
);

    typedef enum logic [2:0] {
        StIdle, StReady, StKeyLd, StDLoad, StRun, StFinish, StDone
    } state_e;

    state_e           state_q;
    logic [KEY_W-1:0] key_q;
    logic [BLK_W-1:0] pt_q;
    logic [BLK_W-1:0] ct_q;
    logic             ct_valid_q;
    logic [4:0]       round_cnt_q;
    logic             key_ready;
    logic             pt_ready;
    logic             key_hs;
    logic             pt_hs;

`ifdef PRESENT_ENC_CTRL_PT_PREFETCH_EN
    logic [BLK_W-1:0] pf_q;
    logic             pf_valid_q;
`endif

    always_comb begin
        key_ready = 1'b0;
        pt_ready  = 1'b0;
        case (state_q)
            StIdle:  key_ready = 1'b1;
            // A simultaneous key offer wins; the plaintext waits a cycle.
            StReady: begin
                key_ready = 1'b1;
                pt_ready  = ~bus.key_valid;
            end
`ifdef PRESENT_ENC_CTRL_PT_PREFETCH_EN
            StKeyLd, StDLoad, StRun, StFinish, StDone: pt_ready = ~pf_valid_q;
`endif
            default: ;
        endcase
    end

    assign key_hs       = bus.key_valid & key_ready;
    assign pt_hs        = bus.pt_valid & pt_ready;
    assign bus.key_ready = key_ready;
    assign bus.pt_ready  = pt_ready;
    assign bus.ct        = ct_q;
    assign bus.ct_valid  = ct_valid_q;

    assign busy_o = (state_q == StKeyLd) || (state_q == StDLoad) ||
                    (state_q == StRun)   || (state_q == StFinish);

    always_comb begin
        core_key_load_o  = 1'b0;
        core_data_load_o = 1'b0;
        core_data_i_o    = '0;
        if (state_q == StKeyLd) begin
            core_key_load_o = 1'b1;
            core_data_i_o   = key_q;
        end else if (state_q == StDLoad) begin
            core_data_load_o = 1'b1;
            core_data_i_o    = {{(KEY_W - BLK_W){1'b0}}, pt_q};
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            key_q       <= '0;
            pt_q        <= '0;
            ct_q        <= '0;
            ct_valid_q  <= 1'b0;
            round_cnt_q <= '0;
`ifdef PRESENT_ENC_CTRL_PT_PREFETCH_EN
            pf_q        <= '0;
            pf_valid_q  <= 1'b0;
`endif
        end else begin
            case (state_q)
                StIdle: begin
                    if (key_hs) begin
                        key_q   <= bus.key;
                        state_q <= StReady;
                    end
                end
                StReady: begin
                    if (key_hs) begin
                        key_q <= bus.key;
                    end else if (pt_hs) begin
                        pt_q    <= bus.pt;
                        state_q <= StKeyLd;
                    end
                end
                StKeyLd: state_q <= StDLoad;
                StDLoad: begin
                    round_cnt_q <= 5'd1;
                    state_q     <= StRun;
                end
                StRun: begin
                    // Stop counting at the last round so the 5-bit counter never wraps.
                    if (round_cnt_q == 5'(NUM_ROUNDS)) begin
                        state_q <= StFinish;
                    end else begin
                        round_cnt_q <= round_cnt_q + 5'd1;
                    end
                end
                StFinish: begin
                    ct_q       <= core_data_o_i;
                    ct_valid_q <= 1'b1;
                    state_q    <= StDone;
                end
                StDone: begin
                    if (bus.ct_ready) begin
                        ct_valid_q <= 1'b0;
`ifdef PRESENT_ENC_CTRL_PT_PREFETCH_EN
                        if (pf_valid_q) begin
                            pt_q       <= pf_q;
                            pf_valid_q <= 1'b0;
                            state_q    <= StKeyLd;
                        end else if (pt_hs) begin
                            pt_q    <= bus.pt;
                            state_q <= StKeyLd;
                        end else begin
                            state_q <= StReady;
                        end
`else
                        state_q <= StReady;
`endif
                    end
                end
                default: state_q <= StIdle;
            endcase
`ifdef PRESENT_ENC_CTRL_PT_PREFETCH_EN
            // Plaintext arriving while a block is in flight parks in the slot, unless it
            // goes straight to pt_q on the ciphertext handshake.
            if (pt_hs && (state_q != StReady) && !((state_q == StDone) && bus.ct_ready)) begin
                pf_q       <= bus.pt;
                pf_valid_q <= 1'b1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_present_enc_ctrl.sv
// Self-checking bench for present_enc_ctrl with a behavioural PRESENT-80 core attached.
// Expected ciphertexts are published test vectors, scored through a queue.
module tb_present_enc_ctrl;

    localparam int unsigned KEY_W = 80;
    localparam int unsigned BLK_W = 64;
    localparam logic [79:0] KEY_ONES = 80'hFFFF_FFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] PT_ONES  = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] CT_00    = 64'h5579C1387B228445;
    localparam logic [63:0] CT_F0    = 64'hE72C46C0F5945049;
    localparam logic [63:0] CT_0F    = 64'hA112FFC72F68417B;
    localparam logic [63:0] CT_FF    = 64'h3333DCD3213210D2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             busy;
    logic [KEY_W-1:0] core_data_i;
    logic             core_key_load;
    logic             core_data_load;
    logic [BLK_W-1:0] core_data_o;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    logic [63:0] exp_q[$];
    int          hs_q[$];
    logic        ct_valid_prev;

    present_enc_ctrl_if #(.KEY_W(KEY_W), .BLK_W(BLK_W)) bus ();

    present_enc_ctrl #(.NUM_ROUNDS(31), .KEY_W(KEY_W), .BLK_W(BLK_W)) dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .bus              (bus),
        .busy_o           (busy),
        .core_data_i_o    (core_data_i),
        .core_key_load_o  (core_key_load),
        .core_data_load_o (core_data_load),
        .core_data_o_i    (core_data_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- behavioural PRESENT-80 core ----------------
    function automatic logic [3:0] sbox(input logic [3:0] x);
        case (x)
            4'h0: return 4'hC; 4'h1: return 4'h5; 4'h2: return 4'h6; 4'h3: return 4'hB;
            4'h4: return 4'h9; 4'h5: return 4'h0; 4'h6: return 4'hA; 4'h7: return 4'hD;
            4'h8: return 4'h3; 4'h9: return 4'hE; 4'hA: return 4'hF; 4'hB: return 4'h8;
            4'hC: return 4'h4; 4'hD: return 4'h7; 4'hE: return 4'h1; default: return 4'h2;
        endcase
    endfunction

    function automatic logic [63:0] present_round(input logic [63:0] s, input logic [63:0] rk);
        logic [63:0] x;
        logic [63:0] y;
        x = s ^ rk;
        for (int i = 0; i < 16; i++) x[4*i +: 4] = sbox(x[4*i +: 4]);
        y = '0;
        for (int i = 0; i < 63; i++) y[(i * 16) % 63] = x[i];
        y[63] = x[63];
        return y;
    endfunction

    function automatic logic [79:0] key_update(input logic [79:0] k, input logic [4:0] rc);
        logic [79:0] r;
        r = {k[18:0], k[79:19]};
        r[79:76] = sbox(r[79:76]);
        r[19:15] = r[19:15] ^ rc;
        return r;
    endfunction

    logic [79:0] ck_q = '0;
    logic [63:0] cs_q = '0;
    logic [4:0]  crc_q = '0;

    always_ff @(posedge clk) begin
        if (core_key_load) begin
            ck_q <= core_data_i;
        end else if (core_data_load) begin
            cs_q  <= core_data_i[63:0];
            crc_q <= 5'd1;
        end else begin
            cs_q  <= present_round(cs_q, ck_q[79:16]);
            ck_q  <= key_update(ck_q, crc_q);
            crc_q <= crc_q + 5'd1;
        end
    end
    assign core_data_o = cs_q ^ ck_q[79:16];

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [79:0] act, input logic [79:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Scoreboard and per-cycle invariants.
    always @(negedge clk) begin
        if (rst_n) begin
`ifdef PRESENT_ENC_CTRL_PT_PREFETCH_EN
            if (core_key_load) hs_q.push_back(cyc);
`else
            if (bus.pt_valid && bus.pt_ready) hs_q.push_back(cyc + 1);
`endif
            if (bus.ct_valid && !ct_valid_prev) begin
                if (exp_q.size() == 0) begin
                    check("ct_unexpected", 80'(bus.ct), 80'(0));
                end else begin
                    check("ct_value", 80'(bus.ct), 80'(exp_q.pop_front()));
                end
                if (hs_q.size() == 0) check("latency_no_hs", 80'(1), 80'(0));
                else check("latency", 80'(cyc - hs_q.pop_front()), 80'(34));
            end
            check("strobe_excl", 80'(core_key_load & core_data_load), 80'(0));
            check("data_i_idle", (core_key_load | core_data_load) ? 80'(0) : core_data_i, 80'(0));
            check("key_rdy_busy", 80'(busy & bus.key_ready), 80'(0));
        end
        ct_valid_prev <= bus.ct_valid;
    end

    // ---------------- stimulus helpers ----------------
    task automatic load_key(input logic [79:0] k);
        int n = 0;
        bus.key = k;
        bus.key_valid = 1'b1;
        @(negedge clk);
        while (!bus.key_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("key_hs_timeout", 80'(n >= 100), 80'(0));
        @(posedge clk);
        #1 bus.key_valid = 1'b0;
    endtask

    task automatic send_pt(input logic [63:0] p, input logic [63:0] e);
        int n = 0;
        exp_q.push_back(e);
        bus.pt = p;
        bus.pt_valid = 1'b1;
        @(negedge clk);
        while (!bus.pt_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("pt_hs_timeout", 80'(n >= 100), 80'(0));
        @(posedge clk);
        #1 bus.pt_valid = 1'b0;
    endtask

    task automatic wait_ready();
        int n = 0;
        @(negedge clk);
        while (!(bus.key_ready && !busy && !bus.ct_valid) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("ready_timeout", 80'(n >= 200), 80'(0));
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ct_valid();
        int n = 0;
        @(negedge clk);
        while (!bus.ct_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("ct_valid_timeout", 80'(n >= 200), 80'(0));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_key_ready"}, 80'(bus.key_ready), 80'(1));
        check({tag, "_pt_ready"}, 80'(bus.pt_ready), 80'(0));
        check({tag, "_ct_valid"}, 80'(bus.ct_valid), 80'(0));
        check({tag, "_ct"}, 80'(bus.ct), 80'(0));
        check({tag, "_busy"}, 80'(busy), 80'(0));
        check({tag, "_key_load"}, 80'(core_key_load), 80'(0));
        check({tag, "_data_load"}, 80'(core_data_load), 80'(0));
        check({tag, "_data_i"}, core_data_i, 80'(0));
    endtask

    // ---------------- main sequence ----------------
    initial begin
        rst_n = 1'b0;
        bus.key = '0;
        bus.key_valid = 1'b0;
        bus.pt = '0;
        bus.pt_valid = 1'b0;
        bus.ct_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("rst");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // All-zero vector, ciphertext accepted on the first DONE cycle.
        bus.ct_ready = 1'b1;
        load_key(80'h0);
        send_pt(64'h0, CT_00);
        wait_ready();

        // All-ones key; second block without reloading the key.
        load_key(KEY_ONES);
        send_pt(64'h0, CT_F0);
        wait_ready();
        send_pt(PT_ONES, CT_FF);
        wait_ready();

        // Back-pressure in DONE.
        bus.ct_ready = 1'b0;
        send_pt(64'h0, CT_F0);
        wait_ct_valid();
        for (int i = 0; i < 20; i++) begin
            check("hold_ct", 80'(bus.ct), 80'(CT_F0));
            check("hold_pt_ready", 80'(bus.pt_ready), 80'(0));
            check("hold_key_ready", 80'(bus.key_ready), 80'(0));
            @(negedge clk);
        end
        @(posedge clk);
        #1 bus.ct_ready = 1'b1;
        @(negedge clk);
        check("hold_last_valid", 80'(bus.ct_valid), 80'(1));
        @(negedge clk);
        check("release_valid", 80'(bus.ct_valid), 80'(0));
        check("release_key_ready", 80'(bus.key_ready), 80'(1));
        check("release_pt_ready", 80'(bus.pt_ready), 80'(1));
        @(posedge clk);
        #1;

        // Key and plaintext offered together: key first, plaintext a cycle later.
        bus.key = 80'h0;
        bus.key_valid = 1'b1;
        bus.pt = PT_ONES;
        bus.pt_valid = 1'b1;
        exp_q.push_back(CT_0F);
        @(negedge clk);
        check("simul_pt_blocked", 80'(bus.pt_ready), 80'(0));
        check("simul_key_ready", 80'(bus.key_ready), 80'(1));
        @(posedge clk);
        #1 bus.key_valid = 1'b0;
        @(negedge clk);
        check("simul_pt_ready", 80'(bus.pt_ready), 80'(1));
        @(posedge clk);
        #1 bus.pt_valid = 1'b0;
        wait_ready();

        // Reset in the middle of RUN (round 15) aborts the block.
        send_pt(PT_ONES, CT_0F);
        repeat (16) @(posedge clk);
        #2;
        check("mid_busy", 80'(busy), 80'(1));
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        exp_q.delete();
        hs_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        bus.pt = PT_ONES;
        bus.pt_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("nokey_pt_ready", 80'(bus.pt_ready), 80'(0));
            check("nokey_busy", 80'(busy), 80'(0));
            check("nokey_ct_valid", 80'(bus.ct_valid), 80'(0));
        end
        @(posedge clk);
        #1;
        exp_q.push_back(CT_FF);
        load_key(KEY_ONES);
        @(posedge clk);
        #1 bus.pt_valid = 1'b0;
        wait_ready();

`ifdef PRESENT_ENC_CTRL_PT_PREFETCH_EN
        // Two queued plaintexts; the second KEYLD follows the first handshake directly.
        load_key(80'h0);
        send_pt(64'h0, CT_00);
        send_pt(PT_ONES, CT_0F);
        wait_ct_valid();
        @(negedge clk);
        check("pf_keyld_next", 80'(core_key_load), 80'(1));
        wait_ready();
`endif

        repeat (3) @(posedge clk);
        check("sb_empty", 80'(exp_q.size()), 80'(0));
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete (errors so far %0d)", n_errors);
        $fatal(1);
    end

endmodule
